seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-anode seven-segment digits on the board I/O. Software or the core loads a packed hex value, and the block commits it on a frame boundary so the display never shows a mix of old and new digits. It then scans the digits one at a time at a programmable refresh rate. Each digit uses the team's standard hex glyph encoding, with a decimal point and anti-ghosting anode blanking.

---
 rtl/seg7_scan_driver.sv | 183 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed seven-segment scan driver with frame-synchronous commit
// Optional feature macro: SEG7_LZ_BLANK_EN (leading-zero blanking of the committed value)
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{AN_ACTIVE_LOW}};

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                pending_q, pending_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_tick_q, frame_tick_d;

    logic                slot_end;
    logic                wrap;
    logic [3:0]          nibble;
    logic                dp_bit;
    logic                blank;
    logic [DIGITS-1:0]   an_onehot;
    logic [DIGITS-1:0]   an_active;
    logic [6:0]          seg_low;

    // Active-low {g,f,e,d,c,b,a} glyph for one hex nibble
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0:    hex_glyph = 7'b1000000;
            4'h1:    hex_glyph = 7'b1111001;
            4'h2:    hex_glyph = 7'b0100100;
            4'h3:    hex_glyph = 7'b0110000;
            4'h4:    hex_glyph = 7'b0011001;
            4'h5:    hex_glyph = 7'b0010010;
            4'h6:    hex_glyph = 7'b0000010;
            4'h7:    hex_glyph = 7'b1111000;
            4'h8:    hex_glyph = 7'b0000000;
            4'h9:    hex_glyph = 7'b0010000;
            4'hA:    hex_glyph = 7'b0001000;
            4'hB:    hex_glyph = 7'b0000011;
            4'hC:    hex_glyph = 7'b1000110;
            4'hD:    hex_glyph = 7'b0100001;
            4'hE:    hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    // Prescaler/index advance, shadow capture and frame-boundary commit
    always_comb begin
        slot_end     = (presc_q == PRESC_LAST);
        wrap         = slot_end && (idx_q == IDX_LAST);
        presc_d      = slot_end ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        disp_d       = disp_q;
        disp_dp_d    = disp_dp_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        frame_tick_d = wrap;

        if (slot_end) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            shadow_d    = value;
            shadow_dp_d = dp_in;
        end

        if (wrap) begin
            // A load landing on the boundary bypasses the shadow entirely
            if (load) begin
                disp_d    = value;
                disp_dp_d = dp_in;
            end else if (pending_q) begin
                disp_d    = shadow_q;
                disp_dp_d = shadow_dp_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [DIGITS-1:0] lz_mask;
    logic              all_zero;

    // Mark digits whose nibble and every higher nibble are zero; digit 0 always shows
    always_comb begin
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero   = all_zero && (disp_q[4*k +: 4] == 4'h0);
            lz_mask[k] = all_zero;
        end
    end
`endif

    // Select the current digit and form the next registered output drive
    always_comb begin
        nibble    = 4'h0;
        dp_bit    = 1'b0;
        blank     = 1'b0;
        an_onehot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nibble       = disp_q[4*k +: 4];
                dp_bit       = disp_dp_q[k];
                an_onehot[k] = 1'b1;
`ifdef SEG7_LZ_BLANK_EN
                blank        = lz_mask[k];
`endif
            end
        end
        seg_low   = blank ? 7'h7F : hex_glyph(nibble);
        seg_d     = SEG_ACTIVE_LOW ? seg_low : ~seg_low;
        dp_d      = SEG_ACTIVE_LOW ? ~dp_bit : dp_bit;
        // Count 0 of each slot keeps every anode off so the previous digit cannot ghost
        an_active = (presc_q != '0) ? an_onehot : '0;
        an_d      = AN_ACTIVE_LOW ? ~an_active : an_active;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst, load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending, frame_tick;

    logic        rst2, load2;
    logic [15:0] value2;
    logic [3:0]  dp_in2;
    logic [6:0]  seg2;
    logic        dp2;
    logic [3:0]  an2;
    logic        pending2, frame_tick2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .seg(seg), .dp(dp), .an(an), .pending(pending), .frame_tick(frame_tick)
    );

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_inv (
        .clk(clk), .rst(rst2), .load(load2), .value(value2), .dp_in(dp_in2),
        .seg(seg2), .dp(dp2), .an(an2), .pending(pending2), .frame_tick(frame_tick2)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        logic [3:0] one, exp_an;
        int p, d;
        tick;
        tick;
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected 1111", an); end
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg: got %b expected 1111111", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", dp); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pending); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b expected 0", frame_tick); end
        rst = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 32; k++) begin
            tick;
            p = (k - 1) % 4;
            d = ((k - 1) / 4) % 4;
            one = 4'b0001 << d;
            exp_an = (p == 0) ? 4'b1111 : ~one;
            checks++; if (an !== exp_an) begin errors++; $display("FAIL freerun_an cyc %0d: got %b expected %b", k, an, exp_an); end
            checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL freerun_seg cyc %0d: got %b expected 1000000", k, seg); end
            checks++; if (frame_tick !== (k % 16 == 0)) begin errors++; $display("FAIL freerun_frame_tick cyc %0d: got %b expected %b", k, frame_tick, (k % 16 == 0)); end
        end
    endtask

    task automatic test_load;
        logic [6:0] exp_seg;
        logic [3:0] one;
        int p, d;
        for (int g = 0; g < 16 && (cyc % 16) != 5; g++) tick;
        load = 1'b1; value = 16'h1A3F; dp_in = 4'b0100;
        tick;
        load = 1'b0;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL load_pending_set: got %b expected 1", pending); end
        for (int g = 0; g < 16 && (cyc % 16) != 15; g++) tick;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL load_pending_hold: got %b expected 1", pending); end
        tick;
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL load_pending_clear: got %b expected 0", pending); end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL load_frame_tick: got %b expected 1", frame_tick); end
        for (int k = 0; k < 16; k++) begin
            tick;
            p = (cyc - 1) % 4;
            d = ((cyc - 1) / 4) % 4;
            case (d)
                0:       exp_seg = 7'b0001110;
                1:       exp_seg = 7'b0110000;
                2:       exp_seg = 7'b0001000;
                default: exp_seg = 7'b1111001;
            endcase
            checks++; if (seg !== exp_seg) begin errors++; $display("FAIL load_seg digit %0d: got %b expected %b", d, seg, exp_seg); end
            checks++; if (dp !== (d != 2)) begin errors++; $display("FAIL load_dp digit %0d: got %b expected %b", d, dp, (d != 2)); end
            if (p != 0) begin
                one = 4'b0001 << d;
                checks++; if (an !== ~one) begin errors++; $display("FAIL load_an digit %0d: got %b expected %b", d, an, ~one); end
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int g = 0; g < 16 && (cyc % 16) != 2; g++) tick;
        load = 1'b1; value = 16'h1111; dp_in = 4'b0000;
        tick;
        load = 1'b0;
        tick;
        tick;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %b expected 1", pending); end
        load = 1'b1; value = 16'h2222;
        tick;
        load = 1'b0;
        for (int g = 0; g < 16 && (cyc % 16) != 0; g++) tick;
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL b2b_pending_clear: got %b expected 0", pending); end
        for (int k = 0; k < 16; k++) begin
            tick;
            checks++; if (seg !== 7'b0100100) begin errors++; $display("FAIL b2b_seg cyc %0d: got %b expected 0100100", cyc, seg); end
            checks++; if (dp !== 1'b1) begin errors++; $display("FAIL b2b_dp cyc %0d: got %b expected 1", cyc, dp); end
        end
    endtask

    task automatic test_boundary_load;
        logic [6:0] exp_seg;
        logic       saw_pending;
        int d;
        saw_pending = 1'b0;
        for (int g = 0; g < 16 && (cyc % 16) != 15; g++) tick;
        load = 1'b1; value = 16'h0055; dp_in = 4'b0000;
        tick;
        load = 1'b0;
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL bnd_pending_edge: got %b expected 0", pending); end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL bnd_frame_tick: got %b expected 1", frame_tick); end
        for (int k = 0; k < 16; k++) begin
            tick;
            if (pending !== 1'b0) saw_pending = 1'b1;
            d = ((cyc - 1) / 4) % 4;
`ifdef SEG7_LZ_BLANK_EN
            exp_seg = (d < 2) ? 7'b0010010 : 7'b1111111;
`else
            exp_seg = (d < 2) ? 7'b0010010 : 7'b1000000;
`endif
            checks++; if (seg !== exp_seg) begin errors++; $display("FAIL bnd_seg digit %0d: got %b expected %b", d, seg, exp_seg); end
        end
        checks++; if (saw_pending !== 1'b0) begin errors++; $display("FAIL bnd_pending_rose: got %b expected 0", saw_pending); end
    endtask

    task automatic test_reset_mid;
        logic [3:0] one, exp_an;
        int p, d;
        for (int g = 0; g < 16 && (cyc % 16) != 1; g++) tick;
        load = 1'b1; value = 16'h0077; dp_in = 4'b1111;
        tick;
        load = 1'b0;
        for (int g = 0; g < 16 && (cyc % 16) != 9; g++) tick;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rstmid_pending_pre: got %b expected 1", pending); end
        rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'b1111;
        tick;
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rstmid_an: got %b expected 1111", an); end
        checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL rstmid_seg: got %b expected 1111111", seg); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b expected 0", pending); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rstmid_dp: got %b expected 1", dp); end
        rst = 1'b0; load = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            p = (k - 1) % 4;
            d = ((k - 1) / 4) % 4;
            one = 4'b0001 << d;
            exp_an = (p == 0) ? 4'b1111 : ~one;
            checks++; if (an !== exp_an) begin errors++; $display("FAIL rstmid_scan_an cyc %0d: got %b expected %b", k, an, exp_an); end
            checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL rstmid_scan_seg cyc %0d: got %b expected 1000000", k, seg); end
            checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rstmid_scan_pending cyc %0d: got %b expected 0", k, pending); end
            checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rstmid_scan_dp cyc %0d: got %b expected 1", k, dp); end
        end
    endtask

    task automatic test_inverted;
        tick;
        checks++; if (seg2 !== 7'b0000000) begin errors++; $display("FAIL inv_reset_seg: got %b expected 0000000", seg2); end
        checks++; if (an2 !== 4'b0000) begin errors++; $display("FAIL inv_reset_an: got %b expected 0000", an2); end
        checks++; if (dp2 !== 1'b0) begin errors++; $display("FAIL inv_reset_dp: got %b expected 0", dp2); end
        rst2 = 1'b0; load2 = 1'b1; value2 = 16'h0008; dp_in2 = 4'b0000;
        tick;
        load2 = 1'b0;
        checks++; if (pending2 !== 1'b1) begin errors++; $display("FAIL inv_pending: got %b expected 1", pending2); end
        for (int c = 2; c <= 20; c++) begin
            tick;
            if (c == 16) begin
                checks++; if (pending2 !== 1'b0) begin errors++; $display("FAIL inv_commit: got %b expected 0", pending2); end
            end
            if (c == 17) begin
                checks++; if (an2 !== 4'b0000) begin errors++; $display("FAIL inv_ghost_an: got %b expected 0000", an2); end
            end
            if (c >= 18) begin
                checks++; if (an2 !== 4'b0001) begin errors++; $display("FAIL inv_an cyc %0d: got %b expected 0001", c, an2); end
                checks++; if (seg2 !== 7'b1111111) begin errors++; $display("FAIL inv_seg cyc %0d: got %b expected 1111111", c, seg2); end
                checks++; if (dp2 !== 1'b0) begin errors++; $display("FAIL inv_dp cyc %0d: got %b expected 0", c, dp2); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = 16'h0000; dp_in = 4'b0000;
        rst2 = 1'b1; load2 = 1'b0; value2 = 16'h0000; dp_in2 = 4'b0000;
        test_reset;
        test_load;
        test_back_to_back;
        test_boundary_load;
        test_reset_mid;
        test_inverted;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
